vga_burst_responder: RTL

Memory-side responder for the VGA scan-out read port. It accepts a burst request from the display fetch logic (`vga_request`/`vga_address`), acknowledges it, and issues `BURST_WORDS` sequential 32-bit word reads to the SDRAM controller's pipelined read port. It streams the returned words back to the display as `vga_valid`/`vga_rdata` beats and closes each burst with a single `vga_complete` pulse. It sits between the VGA output block and the SDRAM controller.

---
 rtl/vga_burst_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_burst_responder.sv
// VGA scan-out burst responder: turns one display request into BURST_WORDS SDRAM word reads.
// Optional out-of-range guard via VGA_RESP_RANGE_CHECK_EN (zero-filled burst, sticky range_error).
module vga_burst_responder #(
  parameter int          BURST_WORDS          = 8,
  parameter logic [25:0] SCREEN_START_ADDRESS = 26'h3f80000,
  parameter logic [25:0] SCREEN_END_ADDRESS   = 26'h3fcb000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_request,
  input  logic [25:0] vga_address,
  output logic        vga_ack,
  output logic [31:0] vga_rdata,
  output logic        vga_valid,
  output logic        vga_complete,
  output logic        mem_request,
  output logic [25:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        range_error
);

  localparam int            CW   = $clog2(BURST_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_reg;
  logic [25:0]   base_reg;
  logic [CW-1:0] issued_reg;
  logic [CW-1:0] returned_reg;
  logic [25:0]   req_base;
  logic [CW-1:0] issued_inc;
  logic          go_memory;
  logic          zero_fill;
  logic          unused_addr_bits;

  assign req_base         = {vga_address[25:2], 2'b00};
  assign issued_inc       = issued_reg + CW'(1);
  assign unused_addr_bits = ^vga_address[1:0];

`ifdef VGA_RESP_RANGE_CHECK_EN
  logic        zero_fill_reg;
  logic        range_error_reg;
  logic [26:0] req_end;
  logic        req_out_of_range;

  // One extra bit so a burst running past the top of memory still compares as out of range.
  assign req_end          = {1'b0, req_base} + 27'(4 * BURST_WORDS);
  assign req_out_of_range = (req_base < SCREEN_START_ADDRESS) ||
                            (req_end > {1'b0, SCREEN_END_ADDRESS});
  assign go_memory        = !req_out_of_range;
  assign zero_fill        = zero_fill_reg;
  assign range_error      = range_error_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero_fill_reg   <= 1'b0;
      range_error_reg <= 1'b0;
    end else if (state_reg == IDLE && vga_request) begin
      zero_fill_reg <= req_out_of_range;
      if (req_out_of_range) range_error_reg <= 1'b1;
    end
  end
`else
  logic [25:0] unused_range;
  assign unused_range = SCREEN_START_ADDRESS ^ SCREEN_END_ADDRESS;
  assign go_memory    = 1'b1;
  assign zero_fill    = 1'b0;
  assign range_error  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      issued_reg   <= '0;
      returned_reg <= '0;
      vga_ack      <= 1'b0;
      vga_rdata    <= '0;
      vga_valid    <= 1'b0;
      vga_complete <= 1'b0;
      mem_request  <= 1'b0;
      mem_address  <= '0;
    end else begin
      vga_ack      <= 1'b0;
      vga_valid    <= 1'b0;
      vga_complete <= 1'b0;

      // Returns may overlap the issue phase, so they are accepted in every busy state.
      if (state_reg != IDLE && mem_rvalid) begin
        vga_valid    <= 1'b1;
        vga_rdata    <= mem_rdata;
        returned_reg <= returned_reg + CW'(1);
      end

      case (state_reg)
        IDLE: begin
          if (vga_request) begin
            base_reg     <= req_base;
            issued_reg   <= '0;
            returned_reg <= '0;
            vga_ack      <= 1'b1;
            if (go_memory) begin
              mem_request <= 1'b1;
              mem_address <= req_base;
              state_reg   <= ISSUE;
            end else begin
              issued_reg <= LAST;
              state_reg  <= DRAIN;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            issued_reg <= issued_inc;
            if (issued_inc == LAST) begin
              mem_request <= 1'b0;
              state_reg   <= DRAIN;
            end else begin
              mem_address <= base_reg + 26'({issued_inc, 2'b00});
            end
          end
        end
        DRAIN: begin
          if (returned_reg == LAST && issued_reg == LAST) begin
            vga_complete <= 1'b1;
            state_reg    <= DONE;
          end else if (zero_fill) begin
            vga_valid    <= 1'b1;
            vga_rdata    <= '0;
            returned_reg <= returned_reg + CW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
